// File: rtl/rgbw_pkg.sv
// Shared constants, state encoding and timing helpers for the RGBW serial chain.
package rgbw_pkg;

  localparam int unsigned DEF_DATA_SIZE   = 32;
  localparam int unsigned DEF_T0H         = 2;
  localparam int unsigned DEF_T1H         = 4;
  localparam int unsigned DEF_T0L         = 6;
  localparam int unsigned DEF_T1L         = 4;
  localparam int unsigned DEF_STR_RST     = 20;
  localparam int unsigned DEF_COUNTER_MAX = 7800;

  // Decoder state encoding
  localparam logic [1:0] ST_WAIT_RST = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_HIGH     = 2'd2;
  localparam logic [1:0] ST_LOW      = 2'd3;

  // Midpoint between nominal 0 and 1 high widths, rounded up
  function automatic int unsigned thresh(input int unsigned t0h, input int unsigned t1h);
    return (t0h + t1h + 1) / 2;
  endfunction

  // Longest high pulse still accepted as a data bit
  function automatic int unsigned hmax(input int unsigned t1h);
    return 2 * t1h;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rgbw_sig_decode.sv
// Single-wire RGBW receiver: classifies high pulses by width, assembles
// MSB-first words, writes them to a FIFO and flags strip-reset frame gaps.
module rgbw_sig_decode
  import rgbw_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = DEF_DATA_SIZE,
  parameter int unsigned RGBW_T0H     = DEF_T0H,
  parameter int unsigned RGBW_T1H     = DEF_T1H,
  parameter int unsigned RGBW_STR_RST = DEF_STR_RST,
  parameter int unsigned COUNTER_MAX  = DEF_COUNTER_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_sig,
  input  logic                 in_wr_fifo_full,
  output logic                 out_wr_fifo_en,
  output logic [DATA_SIZE-1:0] out_wr_fifo_data,
  output logic                 out_frame_done,
  output logic                 out_err_overflow,
  output logic                 out_err_pulse
);

  localparam int unsigned THRESH = thresh(RGBW_T0H, RGBW_T1H);
  localparam int unsigned HMAX   = hmax(RGBW_T1H);
  localparam int unsigned CW     = $clog2(COUNTER_MAX + 1);
  localparam int unsigned BW     = $clog2(DATA_SIZE + 1);

  localparam logic [CW-1:0] THRESH_C  = CW'(THRESH);
  localparam logic [CW-1:0] HMAX_C    = CW'(HMAX);
  localparam logic [CW-1:0] STR_RST_C = CW'(RGBW_STR_RST);
  localparam logic [CW-1:0] CNT_MAX_C = CW'(COUNTER_MAX);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_SIZE - 1);

  logic                 s;
  logic                 s_d;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_next_c;
  logic                 rise_c;
  logic                 fall_c;
  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [DATA_SIZE-1:0] word;
  logic [BW-1:0]        bit_cnt;
  logic                 word_pend;
  logic                 seen_rise;
  logic                 shift_en_c;
  logic                 bit_c;
  logic                 clr_word_c;
  logic                 err_pulse_c;
  logic                 frame_done_c;

  sync_2ff #(
    .RST_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_sig),
    .q   (s)
  );

  assign rise_c = s & ~s_d;
  assign fall_c = ~s & s_d;

  // Run length of the current level including this sample, saturating
  always_comb begin
    cnt_next_c = cnt;
    if (s != s_d) begin
      cnt_next_c = CW'(1);
    end else if (cnt != CNT_MAX_C) begin
      cnt_next_c = cnt + CW'(1);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_WAIT_RST;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-clock control decisions
  always_comb begin
    state_next   = state;
    shift_en_c   = 1'b0;
    bit_c        = 1'b0;
    clr_word_c   = 1'b0;
    err_pulse_c  = 1'b0;
    frame_done_c = 1'b0;
    case (state)
      ST_WAIT_RST: begin
        if (!s && (cnt_next_c >= STR_RST_C)) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rise_c) begin
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (s && (cnt_next_c > HMAX_C)) begin
          err_pulse_c = 1'b1;
          clr_word_c  = 1'b1;
          state_next  = ST_WAIT_RST;
        end else if (fall_c) begin
          shift_en_c = 1'b1;
          bit_c      = (cnt >= THRESH_C);
          state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rise_c) begin
          state_next = ST_HIGH;
        end else if (!s && (cnt_next_c == STR_RST_C)) begin
          clr_word_c   = 1'b1;
          frame_done_c = seen_rise;
          state_next   = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_WAIT_RST;
      end
    endcase
  end

  // Line history and width counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d <= 1'b0;
      cnt <= '0;
    end else begin
      s_d <= s;
      cnt <= cnt_next_c;
    end
  end

  // Word assembly; a completed word is handled on the clock after its last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word      <= '0;
      bit_cnt   <= '0;
      word_pend <= 1'b0;
    end else begin
      word_pend <= 1'b0;
      if (clr_word_c || word_pend) begin
        word    <= '0;
        bit_cnt <= '0;
      end else if (shift_en_c) begin
        word      <= {word[DATA_SIZE-2:0], bit_c};
        bit_cnt   <= bit_cnt + BW'(1);
        word_pend <= (bit_cnt == LAST_BIT);
      end
    end
  end

  // Tracks whether the current frame has carried any pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_rise <= 1'b0;
    end else if ((state == ST_WAIT_RST) || frame_done_c) begin
      seen_rise <= 1'b0;
    end else if (rise_c) begin
      seen_rise <= 1'b1;
    end
  end

  // FIFO write strobe, frame pulse and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_wr_fifo_en   <= 1'b0;
      out_wr_fifo_data <= '0;
      out_frame_done   <= 1'b0;
      out_err_overflow <= 1'b0;
      out_err_pulse    <= 1'b0;
    end else begin
      out_wr_fifo_en <= 1'b0;
      out_frame_done <= frame_done_c;
      if (err_pulse_c) begin
        out_err_pulse <= 1'b1;
      end
      if (word_pend) begin
        if (!in_wr_fifo_full) begin
          out_wr_fifo_en   <= 1'b1;
          out_wr_fifo_data <= word;
        end else begin
          out_err_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgbw_sig_decode.sv
// Scoreboard bench for rgbw_sig_decode: stimulus pushes expected FIFO words,
// a monitor pops and compares on every write strobe and frame pulse.
module tb_rgbw_sig_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_sig;
  logic        in_wr_fifo_full;
  logic        out_wr_fifo_en;
  logic [31:0] out_wr_fifo_data;
  logic        out_frame_done;
  logic        out_err_overflow;
  logic        out_err_pulse;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  int          frames_seen = 0;
  int          frames_exp = 0;
  logic        exp_ov = 1'b0;
  logic        exp_pe = 1'b0;

  always #5 clk = ~clk;

  rgbw_sig_decode dut (
    .clk              (clk),
    .rst              (rst),
    .in_sig           (in_sig),
    .in_wr_fifo_full  (in_wr_fifo_full),
    .out_wr_fifo_en   (out_wr_fifo_en),
    .out_wr_fifo_data (out_wr_fifo_data),
    .out_frame_done   (out_frame_done),
    .out_err_overflow (out_err_overflow),
    .out_err_pulse    (out_err_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Monitor: every strobe must match the oldest expected word; frame pulses
  // must follow all pending writes.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_wr_fifo_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got data %08h expected no strobe", out_wr_fifo_data);
        end else begin
          check("wr_data", out_wr_fifo_data, exp_q.pop_front());
        end
      end
      if (out_frame_done === 1'b1) begin
        frames_seen++;
        check("writes_pending_at_frame_done", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic line(input logic lvl, input int n);
    in_sig = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    line(1'b1, hi);
    line(1'b0, lo);
  endtask

  task automatic send_bits_nom(input logic [31:0] w, input int nbits);
    for (int i = 31; i > 31 - nbits; i--) begin
      if (w[i]) send_bit(1'b1, 4, 4);
      else      send_bit(1'b0, 2, 6);
    end
  endtask

  // Random widths anywhere inside the legal window for each symbol
  task automatic send_word_rand(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin
      if (w[i]) send_bit(1'b1, int'($urandom_range(8, 3)), int'($urandom_range(8, 1)));
      else      send_bit(1'b0, int'($urandom_range(2, 1)), int'($urandom_range(8, 1)));
    end
  endtask

  task automatic expect_word(input logic [31:0] w);
    if (!in_wr_fifo_full) exp_q.push_back(w);
    else exp_ov = 1'b1;
  endtask

  task automatic gap();
    line(1'b0, 25);
  endtask

  task automatic checkpoint(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_frames"}, 32'(frames_seen), 32'(frames_exp));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_err_ovf"}, 32'(out_err_overflow), 32'(exp_ov));
    check({tag, "_err_pulse"}, 32'(out_err_pulse), 32'(exp_pe));
  endtask

  task automatic do_reset(input logic lvl);
    rst = 1'b1;
    in_sig = lvl;
    repeat (3) @(negedge clk);
    check("rst_en", 32'(out_wr_fifo_en), 32'd0);
    check("rst_data", out_wr_fifo_data, 32'd0);
    check("rst_frame", 32'(out_frame_done), 32'd0);
    check("rst_ovf", 32'(out_err_overflow), 32'd0);
    check("rst_pulse", 32'(out_err_pulse), 32'd0);
    exp_q.delete();
    exp_ov = 1'b0;
    exp_pe = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    in_wr_fifo_full = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // Nominal frame
    gap();
    expect_word(32'hA5C30F81);
    send_bits_nom(32'hA5C30F81, 32);
    gap(); frames_exp++;
    checkpoint("nominal");

    // Back-to-back words in one frame
    expect_word(32'hFFFFFFFF); send_bits_nom(32'hFFFFFFFF, 32);
    expect_word(32'h00000001); send_bits_nom(32'h00000001, 32);
    gap(); frames_exp++;
    checkpoint("b2b");

    // FIFO full drops the word and sets the sticky overflow flag
    in_wr_fifo_full = 1'b1;
    expect_word(32'h12345678); send_bits_nom(32'h12345678, 32);
    gap(); frames_exp++;
    in_wr_fifo_full = 1'b0;
    checkpoint("full");
    w = $urandom;
    expect_word(w); send_word_rand(w);
    gap(); frames_exp++;
    checkpoint("after_full");

    // Partial word discarded at frame gap
    send_bits_nom(32'hDEADBEEF, 10);
    gap(); frames_exp++;
    expect_word(32'h0000FFFF); send_bits_nom(32'h0000FFFF, 32);
    gap(); frames_exp++;
    checkpoint("partial");

    // Overlong high pulse mid-word
    send_bits_nom(32'hF0F0F0F0, 7);
    line(1'b1, 9);
    gap(); exp_pe = 1'b1;
    checkpoint("long_pulse");
    w = $urandom;
    expect_word(w); send_word_rand(w);
    gap(); frames_exp++;
    checkpoint("after_long");

    // Boundary widths: 3 and 8 clocks are ones, 2 is a zero
    expect_word(32'hC3000000);
    send_bit(1'b1, 3, 1); send_bit(1'b1, 8, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 2, 1);
    send_bit(1'b1, 3, 3); send_bit(1'b1, 8, 5);
    for (int i = 0; i < 24; i++) send_bit(1'b0, 2, 2);
    gap(); frames_exp++;
    checkpoint("widths");

    // Randomized frames of 1..3 words, occasionally with the FIFO full
    for (int f = 0; f < 12; f++) begin
      in_wr_fifo_full = ($urandom_range(5, 0) == 0);
      for (int k = 0; k < int'($urandom_range(3, 1)); k++) begin
        w = $urandom;
        expect_word(w);
        send_word_rand(w);
      end
      gap(); frames_exp++;
      in_wr_fifo_full = 1'b0;
    end
    checkpoint("random");

    // Reset mid-word: outputs clear, line ignored until a full gap
    send_bits_nom(32'hAAAA5555, 16);
    do_reset(1'b0);
    send_bits_nom(32'h13579BDF, 32);
    gap();
    checkpoint("rst_ignore");
    expect_word(32'h2468ACE0); send_bits_nom(32'h2468ACE0, 32);
    gap(); frames_exp++;
    checkpoint("rst_recover");

    // Power-up with the line held high decodes nothing
    do_reset(1'b1);
    line(1'b1, 100);
    checkpoint("held_high");
    gap();
    w = $urandom;
    expect_word(w); send_word_rand(w);
    gap(); frames_exp++;
    checkpoint("after_high");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
